// File: rtl/ysyx_22040125_ifu_fetch.sv
// ysyx_22040125_ifu_fetch: sequential instruction fetch with a small PC/instruction FIFO and redirect flush
module ysyx_22040125_ifu_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_redirect_valid,
    input  logic [63:0] i_redirect_pc,
    input  logic        i_out_ready,
    output logic        o_out_valid,
    output logic [31:0] o_out_inst,
    output logic [63:0] o_out_pc,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [63:0] o_imem_req_addr,
    input  logic        i_imem_resp_valid,
    input  logic [31:0] i_imem_resp_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
    state_t          r_state;
    logic [63:0]     r_fetch_pc;
    logic [63:0]     r_pend_pc;
    logic [63:0]     r_pc_q   [FIFO_DEPTH];
    logic [31:0]     r_inst_q [FIFO_DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic            w_fire;
    logic            w_push;
    logic            w_pop;
    logic            w_flush;
    assign o_imem_req_valid = (r_state == REQ) && (r_count < CW'(FIFO_DEPTH));
    assign o_imem_req_addr  = r_fetch_pc;
    assign o_out_valid      = r_count != '0;
    assign o_out_pc         = r_pc_q[r_rd_ptr];
    assign o_out_inst       = r_inst_q[r_rd_ptr];
    assign w_fire  = o_imem_req_valid && i_imem_req_ready;
    assign w_flush = i_redirect_valid && (r_state != IDLE);
    assign w_push  = (r_state == WAIT) && i_imem_resp_valid && !i_redirect_valid;
    assign w_pop   = o_out_valid && i_out_ready && !i_redirect_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_pend_pc  <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_pc_q[i]   <= '0;
                r_inst_q[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (w_fire) begin
                        r_pend_pc  <= r_fetch_pc;
                        r_fetch_pc <= r_fetch_pc + 64'd4;
                        r_state    <= i_redirect_valid ? DROP : WAIT;
                    end
                end
                WAIT: r_state <= i_imem_resp_valid ? REQ : (i_redirect_valid ? DROP : WAIT);
                // The outstanding response always retires DROP, even alongside a new redirect
                DROP: r_state <= i_imem_resp_valid ? REQ : DROP;
                default: r_state <= IDLE;
            endcase
            if (w_flush)
                r_fetch_pc <= i_redirect_pc & ~64'd3;
            if (w_flush) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_pc_q[r_wr_ptr]   <= r_pend_pc;
                    r_inst_q[r_wr_ptr] <= i_imem_resp_data;
                    r_wr_ptr           <= r_wr_ptr + AW'(1);
                end
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end
endmodule
